// File: rtl/tcm_mem_multi.sv
// tcm_mem_multi: dual-port tightly-coupled memory model.
// The instruction and data ports share one byte array. Each port has its own
// fixed-latency response pipe. A byte-wide backdoor port preloads images.
module tcm_mem_multi #(
  parameter int unsigned SIZE_BYTES = 131072,
  parameter logic [31:0] BASE_ADDR  = 32'h80000000,
  parameter int unsigned I_LATENCY  = 1,
  parameter int unsigned D_LATENCY  = 1,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_i_rd_i,
  input  logic        mem_i_flush_i,
  input  logic        mem_i_invalidate_i,
  input  logic [31:0] mem_i_pc_i,
  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic        mem_i_error_o,
  output logic [31:0] mem_i_inst_o,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_flush_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic [10:0] mem_d_resp_tag_o,
  input  logic        load_wr_i,
  input  logic [31:0] load_addr_i,
  input  logic [7:0]  load_data_i
);

  localparam int unsigned AW = $clog2(SIZE_BYTES);

  logic [7:0]    mem [SIZE_BYTES];
  logic [15:0]   lfsr;
  logic          accept;

  logic          i_req;
  logic          i_in_range;
  logic [AW-3:0] i_word;
  logic [31:0]   i_rdata;
  logic [31:0]   i_resp;

  logic          d_is_wr;
  logic          d_req;
  logic          d_in_range;
  logic [AW-3:0] d_word;
  logic [31:0]   d_rdata;
  logic [31:0]   d_resp;
  logic          d_wr_en;

  logic          load_ok;
  logic          unused_bits;

  logic [I_LATENCY-1:0] i_vld_pipe;
  logic [I_LATENCY-1:0] i_err_pipe;
  logic [31:0]          i_data_pipe [I_LATENCY];

  logic [D_LATENCY-1:0] d_vld_pipe;
  logic [D_LATENCY-1:0] d_err_pipe;
  logic [31:0]          d_data_pipe [D_LATENCY];
  logic [10:0]          d_tag_pipe  [D_LATENCY];

  assign unused_bits = ^{mem_d_cacheable_i, mem_i_pc_i[1:0], mem_d_addr_i[1:0]};

  // Both ports share one throttle decision; nothing is accepted while in reset.
  assign accept         = !rst_i && ((STALL_EN == 1'b0) || (lfsr[1:0] != 2'b00));
  assign mem_i_accept_o = accept;
  assign mem_d_accept_o = accept;

  // Because BASE_ADDR is aligned to SIZE_BYTES, the range check reduces to
  // comparing the bits above the array offset.
  assign i_in_range = (mem_i_pc_i[31:AW] == BASE_ADDR[31:AW]);
  assign d_in_range = (mem_d_addr_i[31:AW] == BASE_ADDR[31:AW]);
  assign load_ok    = load_wr_i && (load_addr_i[31:AW] == '0);

  assign i_word = mem_i_pc_i[AW-1:2];
  assign d_word = mem_d_addr_i[AW-1:2];

  assign i_rdata = {mem[{i_word, 2'd3}], mem[{i_word, 2'd2}],
                    mem[{i_word, 2'd1}], mem[{i_word, 2'd0}]};
  assign d_rdata = {mem[{d_word, 2'd3}], mem[{d_word, 2'd2}],
                    mem[{d_word, 2'd1}], mem[{d_word, 2'd0}]};

  // Flush and invalidate complete like fetches but return zero; so do misses
  // outside the window.
  assign i_req  = accept && (mem_i_rd_i || mem_i_flush_i || mem_i_invalidate_i);
  assign i_resp = (mem_i_rd_i && i_in_range) ? i_rdata : 32'd0;

  // Any strobe turns the request into a write, whose ack carries zero data.
  assign d_is_wr = (mem_d_wr_i != 4'b0000);
  assign d_req   = accept && (mem_d_rd_i || d_is_wr || mem_d_flush_i || mem_d_invalidate_i);
  assign d_resp  = (mem_d_rd_i && !d_is_wr && d_in_range) ? d_rdata : 32'd0;
  assign d_wr_en = accept && d_is_wr && d_in_range;

  // Accept throttle LFSR (x^16+x^14+x^13+x^11), free-running outside reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Array update: the backdoor write comes last so it wins a same-byte clash.
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < 4; n++) begin
      if (d_wr_en && mem_d_wr_i[n]) begin
        mem[{d_word, n[1:0]}] <= mem_d_data_wr_i[8*n +: 8];
      end
    end
    if (load_ok) begin
      mem[load_addr_i[AW-1:0]] <= load_data_i;
    end
  end

  // Instruction response pipe; reset drops anything still in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_vld_pipe <= '0;
      i_err_pipe <= '0;
      for (int n = 0; n < int'(I_LATENCY); n++) begin
        i_data_pipe[n] <= '0;
      end
    end else begin
      i_vld_pipe[0]  <= i_req;
      i_err_pipe[0]  <= i_req && !i_in_range;
      i_data_pipe[0] <= i_req ? i_resp : 32'd0;
      for (int n = 1; n < int'(I_LATENCY); n++) begin
        i_vld_pipe[n]  <= i_vld_pipe[n-1];
        i_err_pipe[n]  <= i_err_pipe[n-1];
        i_data_pipe[n] <= i_data_pipe[n-1];
      end
    end
  end

  // Data response pipe carrying the echoed tag; reset drops anything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_vld_pipe <= '0;
      d_err_pipe <= '0;
      for (int n = 0; n < int'(D_LATENCY); n++) begin
        d_data_pipe[n] <= '0;
        d_tag_pipe[n]  <= '0;
      end
    end else begin
      d_vld_pipe[0]  <= d_req;
      d_err_pipe[0]  <= d_req && !d_in_range;
      d_data_pipe[0] <= d_req ? d_resp : 32'd0;
      d_tag_pipe[0]  <= d_req ? mem_d_req_tag_i : 11'd0;
      for (int n = 1; n < int'(D_LATENCY); n++) begin
        d_vld_pipe[n]  <= d_vld_pipe[n-1];
        d_err_pipe[n]  <= d_err_pipe[n-1];
        d_data_pipe[n] <= d_data_pipe[n-1];
        d_tag_pipe[n]  <= d_tag_pipe[n-1];
      end
    end
  end

  assign mem_i_valid_o    = i_vld_pipe[I_LATENCY-1];
  assign mem_i_error_o    = i_err_pipe[I_LATENCY-1];
  assign mem_i_inst_o     = i_data_pipe[I_LATENCY-1];
  assign mem_d_ack_o      = d_vld_pipe[D_LATENCY-1];
  assign mem_d_error_o    = d_err_pipe[D_LATENCY-1];
  assign mem_d_data_rd_o  = d_data_pipe[D_LATENCY-1];
  assign mem_d_resp_tag_o = d_tag_pipe[D_LATENCY-1];

endmodule

// File: tb/tb_tcm_mem_multi.sv
// Bench for tcm_mem_multi. Three instances: u0 (latency 1/1), u1 (i=2, d=3),
// both driven by input set 0, and u2 (stall throttling, 1 KiB) on input set 1.
// A per-instance reference model schedules every expected response by its due
// cycle and checks every output every cycle; directed tables add fixed values.
module tb_tcm_mem_multi;

  localparam logic [31:0] BASE = 32'h80000000;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    bit          v;
    bit          err;
    logic [31:0] data;
    logic [31:0] mask;
    logic [10:0] tag;
  } resp_t;

  typedef struct {
    bit          rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [10:0] tag;
    logic [31:0] exp_data;
    bit          exp_err;
  } dvec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        i_rd [2];
  logic        i_flush [2];
  logic        i_inv [2];
  logic [31:0] i_pc [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        d_rd [2];
  logic [3:0]  d_wr [2];
  logic        d_cache [2];
  logic [10:0] d_tag [2];
  logic        d_inv [2];
  logic        d_flush [2];
  logic        ld_wr [2];
  logic [31:0] ld_addr [2];
  logic [7:0]  ld_data [2];

  logic        i_acc [3];
  logic        i_valid [3];
  logic        i_err [3];
  logic [31:0] i_inst [3];
  logic        d_acc [3];
  logic        d_ack [3];
  logic        d_err [3];
  logic [31:0] d_rdata [3];
  logic [10:0] d_rtag [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a, input int sz);
    longint la;
    la = longint'({32'd0, a});
    return (la >= longint'({32'd0, BASE})) && (la < longint'({32'd0, BASE}) + longint'(sz));
  endfunction

  // Reference model and DUT per instance
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int S  = (g == 2) ? 1 : 0;
    localparam int IL = (g == 0) ? 1 : 2;
    localparam int DL = (g == 1) ? 3 : 1;
    localparam bit ST = (g == 2);
    localparam int SZ = (g == 2) ? 1024 : 131072;

    tcm_mem_multi #(
      .SIZE_BYTES(SZ), .BASE_ADDR(BASE), .I_LATENCY(IL), .D_LATENCY(DL),
      .STALL_EN(ST), .LFSR_SEED(SEED)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .mem_i_rd_i(i_rd[S]), .mem_i_flush_i(i_flush[S]), .mem_i_invalidate_i(i_inv[S]),
      .mem_i_pc_i(i_pc[S]), .mem_i_accept_o(i_acc[g]), .mem_i_valid_o(i_valid[g]),
      .mem_i_error_o(i_err[g]), .mem_i_inst_o(i_inst[g]),
      .mem_d_addr_i(d_addr[S]), .mem_d_data_wr_i(d_wdata[S]), .mem_d_rd_i(d_rd[S]),
      .mem_d_wr_i(d_wr[S]), .mem_d_cacheable_i(d_cache[S]), .mem_d_req_tag_i(d_tag[S]),
      .mem_d_invalidate_i(d_inv[S]), .mem_d_flush_i(d_flush[S]),
      .mem_d_accept_o(d_acc[g]), .mem_d_ack_o(d_ack[g]), .mem_d_error_o(d_err[g]),
      .mem_d_data_rd_o(d_rdata[g]), .mem_d_resp_tag_o(d_rtag[g]),
      .load_wr_i(ld_wr[S]), .load_addr_i(ld_addr[S]), .load_data_i(ld_data[S])
    );

    logic [7:0]  mm [SZ];
    bit          kn [SZ];
    resp_t       ie [8];
    resp_t       de [8];
    resp_t       r;
    logic [15:0] lm = SEED;
    int unsigned cyc = 0;
    int          sl;
    int          off;
    bit          acc_exp;

    // Compare outputs against the schedule, then book this cycle's requests
    always @(negedge clk) begin
      sl = int'(cyc % 8);
      if (ie[sl].v) begin
        chk($sformatf("u%0d.i_valid", g), {31'd0, i_valid[g]}, 32'd1);
        chk($sformatf("u%0d.i_err", g), {31'd0, i_err[g]}, {31'd0, ie[sl].err});
        chk($sformatf("u%0d.i_inst", g), i_inst[g] & ie[sl].mask, ie[sl].data & ie[sl].mask);
      end else begin
        chk($sformatf("u%0d.i_valid", g), {31'd0, i_valid[g]}, 32'd0);
      end
      if (de[sl].v) begin
        chk($sformatf("u%0d.d_ack", g), {31'd0, d_ack[g]}, 32'd1);
        chk($sformatf("u%0d.d_err", g), {31'd0, d_err[g]}, {31'd0, de[sl].err});
        chk($sformatf("u%0d.d_tag", g), {21'd0, d_rtag[g]}, {21'd0, de[sl].tag});
        chk($sformatf("u%0d.d_data", g), d_rdata[g] & de[sl].mask, de[sl].data & de[sl].mask);
      end else begin
        chk($sformatf("u%0d.d_ack", g), {31'd0, d_ack[g]}, 32'd0);
      end
      ie[sl].v = 1'b0;
      de[sl].v = 1'b0;

      acc_exp = !rst && (!ST || (lm[1:0] != 2'b00));
      chk($sformatf("u%0d.i_accept", g), {31'd0, i_acc[g]}, {31'd0, acc_exp});
      chk($sformatf("u%0d.d_accept", g), {31'd0, d_acc[g]}, {31'd0, acc_exp});

      if (rst) begin
        for (int k = 0; k < 8; k++) begin
          ie[k].v = 1'b0;
          de[k].v = 1'b0;
        end
      end else if (acc_exp) begin
        if (i_rd[S] || i_flush[S] || i_inv[S]) begin
          r.v = 1'b1; r.err = !in_rng(i_pc[S], SZ); r.data = '0; r.mask = '1; r.tag = '0;
          if (i_rd[S] && !r.err) begin
            off = int'(i_pc[S] - BASE) & ~3;
            for (int b = 0; b < 4; b++) begin
              r.data[8*b +: 8] = mm[off + b];
              r.mask[8*b +: 8] = kn[off + b] ? 8'hFF : 8'h00;
            end
          end
          ie[int'((cyc + IL) % 8)] = r;
        end
        if (d_rd[S] || (d_wr[S] != 4'b0) || d_flush[S] || d_inv[S]) begin
          r.v = 1'b1; r.err = !in_rng(d_addr[S], SZ); r.data = '0; r.mask = '1; r.tag = d_tag[S];
          off = int'(d_addr[S] - BASE) & ~3;
          if (d_rd[S] && (d_wr[S] == 4'b0) && !r.err) begin
            for (int b = 0; b < 4; b++) begin
              r.data[8*b +: 8] = mm[off + b];
              r.mask[8*b +: 8] = kn[off + b] ? 8'hFF : 8'h00;
            end
          end
          de[int'((cyc + DL) % 8)] = r;
          if ((d_wr[S] != 4'b0) && !r.err) begin
            for (int b = 0; b < 4; b++) begin
              if (d_wr[S][b]) begin
                mm[off + b] = d_wdata[S][8*b +: 8];
                kn[off + b] = 1'b1;
              end
            end
          end
        end
      end
      if (ld_wr[S] && (ld_addr[S] < SZ)) begin
        mm[int'(ld_addr[S])] = ld_data[S];
        kn[int'(ld_addr[S])] = 1'b1;
      end
      lm  = rst ? SEED : {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};
      cyc = cyc + 1;
    end
  end

  task automatic idle(input int s);
    i_rd[s] = 0; i_flush[s] = 0; i_inv[s] = 0; i_pc[s] = '0;
    d_addr[s] = '0; d_wdata[s] = '0; d_rd[s] = 0; d_wr[s] = '0; d_cache[s] = 0;
    d_tag[s] = '0; d_inv[s] = 0; d_flush[s] = 0;
    ld_wr[s] = 0; ld_addr[s] = '0; ld_data[s] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int s, input bit rd, input logic [3:0] wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [10:0] tag);
    idle(s);
    d_rd[s] = rd; d_wr[s] = wr; d_addr[s] = addr; d_wdata[s] = wdata; d_tag[s] = tag;
  endtask

  task automatic checkOutput(input int k, input string t, input bit ack,
                             input logic [10:0] tag, input logic [31:0] data, input bit err);
    chk({t, ".ack"}, {31'd0, d_ack[k]}, {31'd0, ack});
    if (ack) begin
      chk({t, ".tag"}, {21'd0, d_rtag[k]}, {21'd0, tag});
      chk({t, ".data"}, d_rdata[k], data);
      chk({t, ".err"}, {31'd0, d_err[k]}, {31'd0, err});
    end
  endtask

  task automatic check_fetch(input int k, input string t, input bit vld,
                             input logic [31:0] data, input bit err);
    chk({t, ".valid"}, {31'd0, i_valid[k]}, {31'd0, vld});
    if (vld) begin
      chk({t, ".inst"}, i_inst[k], data);
      chk({t, ".err"}, {31'd0, i_err[k]}, {31'd0, err});
    end
  endtask

  task automatic rand_ops(input int s);
    int r;
    idle(s);
    r = $urandom_range(0, 9);
    i_rd[s] = (r < 7); i_flush[s] = (r == 7); i_inv[s] = (r == 8);
    i_pc[s] = rand_addr();
    r = $urandom_range(0, 9);
    d_rd[s] = (r <= 3) || (r == 5);
    d_wr[s] = (r >= 4 && r <= 6) ? 4'($urandom_range(1, 15)) : 4'h0;
    d_flush[s] = (r == 7); d_inv[s] = (r == 8);
    d_addr[s] = rand_addr(); d_wdata[s] = $urandom; d_tag[s] = 11'($urandom);
    d_cache[s] = 1'($urandom);
    if ($urandom_range(0, 4) == 0) begin
      ld_wr[s] = 1; ld_addr[s] = 32'($urandom_range(0, 1100)); ld_data[s] = 8'($urandom);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return BASE + 32'd1024 + 32'($urandom_range(0, 63) * 4);
    if (r == 1) return BASE - 32'($urandom_range(1, 8) * 4);
    return BASE + 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
  endfunction

  dvec_t tbl [10];

  initial begin
    tbl[0] = '{1'b0, 4'hF, 32'h80000010, 32'hDEADBEEF, 11'h005, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 4'h0, 32'h80000010, 32'h0,        11'h00A, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 4'h2, 32'h80000010, 32'h00001100, 11'h00B, 32'h0,        1'b0};
    tbl[3] = '{1'b1, 4'h0, 32'h80000010, 32'h0,        11'h00C, 32'hDEAD11EF, 1'b0};
    tbl[4] = '{1'b1, 4'h0, 32'h80020000, 32'h0,        11'h00D, 32'h0,        1'b1};
    tbl[5] = '{1'b0, 4'hF, 32'h80020000, 32'h55555555, 11'h00E, 32'h0,        1'b1};
    tbl[6] = '{1'b1, 4'h0, 32'h80000013, 32'h0,        11'h7FF, 32'hDEAD11EF, 1'b0};
    tbl[7] = '{1'b0, 4'hF, 32'h8001FFFC, 32'hCAFEF00D, 11'h010, 32'h0,        1'b0};
    tbl[8] = '{1'b1, 4'h0, 32'h8001FFFC, 32'h0,        11'h011, 32'hCAFEF00D, 1'b0};
    tbl[9] = '{1'b1, 4'h0, 32'h7FFFFFFC, 32'h0,        11'h012, 32'h0,        1'b1};

    idle(0);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset.u%0d.d_ack", k), {31'd0, d_ack[k]}, 32'd0);
      chk($sformatf("reset.u%0d.d_err", k), {31'd0, d_err[k]}, 32'd0);
      chk($sformatf("reset.u%0d.d_data", k), d_rdata[k], 32'd0);
      chk($sformatf("reset.u%0d.d_tag", k), {21'd0, d_rtag[k]}, 32'd0);
      chk($sformatf("reset.u%0d.i_valid", k), {31'd0, i_valid[k]}, 32'd0);
      chk($sformatf("reset.u%0d.i_inst", k), i_inst[k], 32'd0);
      chk($sformatf("reset.u%0d.accept", k), {30'd0, i_acc[k], d_acc[k]}, 32'd0);
    end
    step();
    rst = 1'b0;

    // Table: writes, strobes, range errors, last word, ignored low bits
    for (int n = 0; n < 10; n++) begin
      step();
      applyStimulus(0, tbl[n].rd, tbl[n].wr, tbl[n].addr, tbl[n].wdata, tbl[n].tag);
      step();
      idle(0);
      @(negedge clk);
      checkOutput(0, $sformatf("vec%0d", n), 1'b1, tbl[n].tag, tbl[n].exp_data, tbl[n].exp_err);
    end

    // Out-of-range fetch on both latencies
    step(); idle(0); i_rd[0] = 1; i_pc[0] = 32'h7FFFFFFC;
    @(negedge clk);
    step(); idle(0);
    @(negedge clk);
    check_fetch(0, "fetch_oor_u0", 1'b1, 32'h0, 1'b1);
    check_fetch(1, "fetch_oor_u1_early", 1'b0, 32'h0, 1'b0);
    step();
    @(negedge clk);
    check_fetch(1, "fetch_oor_u1", 1'b1, 32'h0, 1'b1);

    // Back-to-back reads on the d=3 / i=2 instance
    for (int n = 0; n < 7; n++) begin
      step();
      idle(0);
      if (n == 0) begin
        applyStimulus(0, 1'b1, 4'h0, 32'h80000010, 32'h0, 11'h001);
        i_rd[0] = 1; i_pc[0] = 32'h80000010;
      end
      if (n == 1) applyStimulus(0, 1'b1, 4'h0, 32'h8001FFFC, 32'h0, 11'h002);
      if (n == 2) applyStimulus(0, 1'b1, 4'h0, 32'h80000010, 32'h0, 11'h003);
      @(negedge clk);
      checkOutput(1, $sformatf("b2b_c%0d", n), (n >= 3 && n <= 5), 11'(n - 2),
                  (n == 4) ? 32'hCAFEF00D : 32'hDEAD11EF, 1'b0);
      check_fetch(1, $sformatf("b2b_fetch_c%0d", n), (n == 2), 32'hDEAD11EF, 1'b0);
    end

    // Collision: fetch vs write same word, backdoor vs write same byte
    for (int n = 0; n < 4; n++) begin
      step(); idle(0);
      ld_wr[0] = 1; ld_addr[0] = 32'(n); ld_data[0] = (n == 0) ? 8'hA5 : (n == 1) ? 8'h5A : (n == 2) ? 8'h0F : 8'hF0;
    end
    step();
    applyStimulus(0, 1'b0, 4'hF, 32'h80000000, 32'h11223344, 11'h01E);
    i_rd[0] = 1; i_pc[0] = 32'h80000000;
    ld_wr[0] = 1; ld_addr[0] = 32'h0; ld_data[0] = 8'h77;
    step();
    idle(0);
    ld_wr[0] = 1; ld_addr[0] = 32'h00020000; ld_data[0] = 8'hEE;
    @(negedge clk);
    check_fetch(0, "collide_fetch_old", 1'b1, 32'hF00F5AA5, 1'b0);
    step();
    applyStimulus(0, 1'b1, 4'h0, 32'h80000000, 32'h0, 11'h01F);
    step();
    idle(0);
    @(negedge clk);
    checkOutput(0, "collide_readback", 1'b1, 11'h01F, 32'h11223377, 1'b0);

    // Reset with two reads in flight on the d=3 instance
    for (int n = 0; n < 9; n++) begin
      step();
      idle(0);
      if (n == 0) applyStimulus(0, 1'b0, 4'hF, 32'h80000020, 32'h0BADF00D, 11'h020);
      if (n == 1) applyStimulus(0, 1'b1, 4'h0, 32'h80000020, 32'h0, 11'h021);
      if (n == 2) applyStimulus(0, 1'b1, 4'h0, 32'h80000020, 32'h0, 11'h022);
      rst = (n == 3);
      if (n == 5) applyStimulus(0, 1'b1, 4'h0, 32'h80000020, 32'h0, 11'h023);
      @(negedge clk);
      if (n == 3) chk("rst_mid.accept", {31'd0, d_acc[1]}, 32'd0);
      if (n == 6) checkOutput(0, "rst_mid.u0_keep", 1'b1, 11'h023, 32'h0BADF00D, 1'b0);
      if (n >= 3) checkOutput(1, $sformatf("rst_mid.u1_c%0d", n), (n == 3) || (n == 8),
                              (n == 3) ? 11'h020 : 11'h023, (n == 3) ? 32'h0 : 32'h0BADF00D, 1'b0);
    end

    // Throttled instance: preload, then random traffic checked by its model
    for (int a = 0; a < 256; a++) begin
      step(); idle(1);
      ld_wr[1] = 1; ld_addr[1] = 32'(a); ld_data[1] = 8'($urandom);
    end
    for (int n = 0; n < 260; n++) begin
      step();
      rand_ops(1);
    end
    step();
    idle(0);
    idle(1);
    repeat (8) step();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
